axi_write_arbiter: RTL and testbench

AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

---
 rtl/axi_write_arbiter_pkg.sv | 12 +
 rtl/axi_write_arbiter_rr_selector.sv | 30 +++
 rtl/axi_write_arbiter.sv | 121 ++++++++++++
 tb/tb_axi_write_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_write_arbiter_pkg.sv
// Shared AXI field widths and index helpers for the write-channel arbiter.
package axi_write_arbiter_pkg;

  localparam int BW_AXI_ALEN   = 8;
  localparam int BW_AXI_ASIZE  = 3;
  localparam int BW_AXI_ABURST = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_write_arbiter_rr_selector.sv
// Combinational round-robin pick: first requester above last_grant, wrapping.
module rr_selector
  import axi_write_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int BW_IDX  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [BW_IDX-1:0]  last_grant_i,
  output logic               found_o,
  output logic [BW_IDX-1:0]  index_o
);

  always_comb begin
    int unsigned cand;
    logic        hit;
    hit     = 1'b0;
    index_o = '0;
    cand    = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(last_grant_i) + off) % NUM_REQ;
      if (!hit && req_i[cand[BW_IDX-1:0]]) begin
        hit     = 1'b1;
        index_o = cand[BW_IDX-1:0];
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// N-to-1 AXI write arbiter: grants one requester per burst, AW first, then W until wlast.
module axi_write_arbiter
  import axi_write_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int BW_ADDR    = 32,
  parameter  int BW_DATA    = 32,
  parameter  int BW_AXI_TID = 4,
  localparam int BW_STRB    = BW_DATA / 8,
  localparam int BW_IDX     = idx_width(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rstnn,
  input  logic [NUM_REQ-1:0]                sawvalid,
  output logic [NUM_REQ-1:0]                sawready,
  input  logic [NUM_REQ*BW_AXI_TID-1:0]     sawid,
  input  logic [NUM_REQ*BW_ADDR-1:0]        sawaddr,
  input  logic [NUM_REQ*BW_AXI_ALEN-1:0]    sawlen,
  input  logic [NUM_REQ*BW_AXI_ASIZE-1:0]   sawsize,
  input  logic [NUM_REQ*BW_AXI_ABURST-1:0]  sawburst,
  input  logic [NUM_REQ-1:0]                swvalid,
  output logic [NUM_REQ-1:0]                swready,
  input  logic [NUM_REQ-1:0]                swlast,
  input  logic [NUM_REQ*BW_DATA-1:0]        swdata,
  input  logic [NUM_REQ*BW_STRB-1:0]        swstrb,
  output logic                              mawvalid,
  input  logic                              mawready,
  output logic [BW_AXI_TID-1:0]             mawid,
  output logic [BW_ADDR-1:0]                mawaddr,
  output logic [BW_AXI_ALEN-1:0]            mawlen,
  output logic [BW_AXI_ASIZE-1:0]           mawsize,
  output logic [BW_AXI_ABURST-1:0]          mawburst,
  output logic                              mwvalid,
  input  logic                              mwready,
  output logic                              mwlast,
  output logic [BW_DATA-1:0]                mwdata,
  output logic [BW_STRB-1:0]                mwstrb,
  output logic [BW_IDX-1:0]                 grant_index,
  output logic                              busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_e;

  state_e            state_q;
  logic [BW_IDX-1:0] grant_q;
  logic [BW_IDX-1:0] last_q;
  logic              rr_found;
  logic [BW_IDX-1:0] rr_index;

  rr_selector #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_selector (
    .req_i       (sawvalid),
    .last_grant_i(last_q),
    .found_o     (rr_found),
    .index_o     (rr_index)
  );

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= BW_IDX'(NUM_REQ - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rr_found) begin
            grant_q <= rr_index;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (mawvalid && mawready) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (mwvalid && mwready && mwlast) begin
            last_q  <= grant_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Payload fields follow the owner's slice in every state; only valid/ready are state-gated.
  always_comb begin
    sawready = '0;
    swready  = '0;
    mawvalid = 1'b0;
    mwvalid  = 1'b0;
    mwlast   = 1'b0;
    mawid    = sawid[grant_q*BW_AXI_TID +: BW_AXI_TID];
    mawaddr  = sawaddr[grant_q*BW_ADDR +: BW_ADDR];
    mawlen   = sawlen[grant_q*BW_AXI_ALEN +: BW_AXI_ALEN];
    mawsize  = sawsize[grant_q*BW_AXI_ASIZE +: BW_AXI_ASIZE];
    mawburst = sawburst[grant_q*BW_AXI_ABURST +: BW_AXI_ABURST];
    mwdata   = swdata[grant_q*BW_DATA +: BW_DATA];
    mwstrb   = swstrb[grant_q*BW_STRB +: BW_STRB];
    case (state_q)
      ST_ADDR: begin
        mawvalid          = sawvalid[grant_q];
        sawready[grant_q] = mawready;
      end
      ST_DATA: begin
        mwvalid          = swvalid[grant_q];
        mwlast           = swlast[grant_q];
        swready[grant_q] = mwready;
      end
      default: ;
    endcase
  end

  assign grant_index = grant_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter with a per-cycle transaction-level reference model.
module tb_axi_write_arbiter;

  localparam int N   = 2;
  localparam int IW  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 8;
  localparam int SW  = 3;
  localparam int BBW = 2;
  localparam int STW = DW / 8;

  logic clk = 1'b0;
  logic rstnn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]     sawvalid, sawready, swvalid, swready, swlast;
  logic [N*IW-1:0]  sawid;
  logic [N*AW-1:0]  sawaddr;
  logic [N*LW-1:0]  sawlen;
  logic [N*SW-1:0]  sawsize;
  logic [N*BBW-1:0] sawburst;
  logic [N*DW-1:0]  swdata;
  logic [N*STW-1:0] swstrb;
  logic             mawvalid, mawready, mwvalid, mwready, mwlast, busy;
  logic [IW-1:0]    mawid;
  logic [AW-1:0]    mawaddr;
  logic [LW-1:0]    mawlen;
  logic [SW-1:0]    mawsize;
  logic [BBW-1:0]   mawburst;
  logic [DW-1:0]    mwdata;
  logic [STW-1:0]   mwstrb;
  logic [0:0]       grant_index;

  // Per-requester drive state, packed onto the flattened buses below.
  logic           r_awv [N];
  logic [IW-1:0]  r_id  [N];
  logic [AW-1:0]  r_addr[N];
  logic [LW-1:0]  r_len [N];
  logic [SW-1:0]  r_size[N];
  logic [BBW-1:0] r_bst [N];
  logic           r_wv  [N];
  logic           r_wl  [N];
  logic [DW-1:0]  r_wd  [N];
  logic [STW-1:0] r_ws  [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      sawvalid[k]              = r_awv[k];
      sawid[k*IW +: IW]        = r_id[k];
      sawaddr[k*AW +: AW]      = r_addr[k];
      sawlen[k*LW +: LW]       = r_len[k];
      sawsize[k*SW +: SW]      = r_size[k];
      sawburst[k*BBW +: BBW]   = r_bst[k];
      swvalid[k]               = r_wv[k];
      swlast[k]                = r_wl[k];
      swdata[k*DW +: DW]       = r_wd[k];
      swstrb[k*STW +: STW]     = r_ws[k];
    end
  end

  axi_write_arbiter #(
    .NUM_REQ(N), .BW_ADDR(AW), .BW_DATA(DW), .BW_AXI_TID(IW)
  ) dut (
    .clk(clk), .rstnn(rstnn),
    .sawvalid(sawvalid), .sawready(sawready), .sawid(sawid), .sawaddr(sawaddr),
    .sawlen(sawlen), .sawsize(sawsize), .sawburst(sawburst),
    .swvalid(swvalid), .swready(swready), .swlast(swlast), .swdata(swdata), .swstrb(swstrb),
    .mawvalid(mawvalid), .mawready(mawready), .mawid(mawid), .mawaddr(mawaddr),
    .mawlen(mawlen), .mawsize(mawsize), .mawburst(mawburst),
    .mwvalid(mwvalid), .mwready(mwready), .mwlast(mwlast), .mwdata(mwdata), .mwstrb(mwstrb),
    .grant_index(grant_index), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait budget expired at %0t", nm, $time);
  endtask

  // Slave-side readiness: optional AW stall count and W ready toggling.
  int aw_stall = 0;
  bit w_toggle = 1'b0;
  initial begin
    mawready = 1'b0;
    mwready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (aw_stall > 0) begin
        mawready = 1'b0;
        aw_stall--;
      end else begin
        mawready = 1'b1;
      end
      mwready = w_toggle ? !mwready : 1'b1;
    end
  end

  // Reference model: one owner at a time, AW before W, round-robin from last finisher.
  int m_owner = -1;
  bit m_aw = 1'b0;
  int m_last = N - 1;
  int m_gidx = 0;
  int m_beats = 0;
  int dut_beats = 0;
  int grant_log[$];
  int beats_log[$];

  function automatic int rr_pick(input int last);
    for (int s = 1; s <= N; s++)
      if (r_awv[(last + s) % N]) return (last + s) % N;
    return -1;
  endfunction

  function automatic logic [31:0] enc(input bit beats);
    logic [31:0] c;
    c = '0;
    if (beats) foreach (beats_log[i]) c = (c << 4) | 32'(beats_log[i]);
    else       foreach (grant_log[i]) c = (c << 4) | 32'(grant_log[i]);
    return c;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] e_sar, e_swr;
    logic         e_awv, e_wv;
    int           o;
    if (mwvalid && mwready) dut_beats++;
    if (!rstnn) begin
      chk("reset_valid_ready", {sawready, swready, mawvalid, mwvalid, busy}, '0);
      chk("reset_grant_index", grant_index, 0);
      m_owner = -1; m_aw = 1'b0; m_last = N - 1; m_gidx = 0; m_beats = 0;
    end else begin
      o = m_owner;
      e_sar = '0; e_swr = '0; e_awv = 1'b0; e_wv = 1'b0;
      if (o >= 0 && !m_aw) begin e_awv = r_awv[o]; e_sar[o] = mawready; end
      if (o >= 0 && m_aw)  begin e_wv  = r_wv[o];  e_swr[o] = mwready;  end
      chk("mawvalid", mawvalid, e_awv);
      chk("mwvalid", mwvalid, e_wv);
      chk("sawready", sawready, e_sar);
      chk("swready", swready, e_swr);
      chk("busy", busy, o >= 0);
      chk("grant_index", grant_index, m_gidx);
      if (o >= 0 && !m_aw)
        chk("aw_fields", {mawid, mawaddr, mawlen, mawsize, mawburst},
            {r_id[o], r_addr[o], r_len[o], r_size[o], r_bst[o]});
      if (o >= 0 && m_aw)
        chk("w_fields", {mwdata, mwstrb, mwlast}, {r_wd[o], r_ws[o], r_wl[o]});
      if (o < 0) begin
        o = rr_pick(m_last);
        if (o >= 0) begin
          m_owner = o; m_gidx = o; m_aw = 1'b0;
          grant_log.push_back(o);
        end
      end else if (!m_aw) begin
        if (r_awv[o] && mawready) begin m_aw = 1'b1; m_beats = 0; end
      end else if (r_wv[o] && mwready) begin
        m_beats++;
        if (r_wl[o]) begin
          beats_log.push_back(m_beats);
          m_last = o;
          m_owner = -1;
        end
      end
    end
  end

  task automatic wait_hs(input int k, input bit is_w, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!rstnn) return;
      if (is_w ? swready[k] : sawready[k]) begin
        ok = 1'b1;
        @(posedge clk); #1;
        return;
      end
    end
    timeout(is_w ? "w_handshake" : "aw_handshake");
  endtask

  // One burst from requester k; data words are addr+beat. Called at posedge+1.
  task automatic burst(input int k, input logic [31:0] addr, input int len,
                       input int aw_dly, input int w_dly);
    fork
      begin
        bit ok;
        repeat (aw_dly) begin @(posedge clk); #1; end
        r_id[k] = IW'(k + 3); r_addr[k] = addr; r_len[k] = LW'(len);
        r_size[k] = 3'd2; r_bst[k] = 2'd1; r_awv[k] = 1'b1;
        wait_hs(k, 1'b0, ok);
        r_awv[k] = 1'b0;
      end
      begin
        bit ok;
        repeat (w_dly) begin @(posedge clk); #1; end
        for (int b = 0; b <= len; b++) begin
          r_wv[k] = 1'b1; r_wd[k] = addr + 32'(b);
          r_ws[k] = STW'(b) ^ 4'hF; r_wl[k] = (b == len);
          wait_hs(k, 1'b1, ok);
          if (!ok) break;
        end
        r_wv[k] = 1'b0; r_wl[k] = 1'b0;
      end
    join
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstnn = 1'b0;
    @(negedge clk);
    chk("rst_mawvalid", mawvalid, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rstnn = 1'b1;
    grant_log.delete();
    beats_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit seen;
    for (int k = 0; k < N; k++) begin
      r_awv[k] = 1'b0; r_id[k] = '0; r_addr[k] = '0; r_len[k] = '0; r_size[k] = '0;
      r_bst[k] = '0; r_wv[k] = 1'b0; r_wl[k] = 1'b0; r_wd[k] = '0; r_ws[k] = '0;
    end

    // Single request from requester 1, len 3
    do_reset();
    fork
      burst(1, 32'h100, 3, 0, 0);
      begin
        @(negedge clk);
        chk("t1_arb_cycle_mawvalid", mawvalid, 0);
        @(negedge clk);
        chk("t1_mawvalid_rise", mawvalid, 1);
        chk("t1_grant", grant_index, 1);
        chk("t1_mawaddr", mawaddr, 32'h100);
        chk("t1_mawlen", mawlen, 3);
      end
    join
    @(negedge clk);
    chk("t1_busy_after", busy, 0);
    chk("t1_grants", enc(1'b0), 32'h1);
    chk("t1_beats", enc(1'b1), 32'h4);

    // Simultaneous requests after reset
    do_reset();
    fork
      burst(0, 32'h200, 1, 0, 0);
      burst(1, 32'h300, 2, 0, 0);
    join
    chk("t2_grants", enc(1'b0), 32'h01);
    chk("t2_beats", enc(1'b1), 32'h23);

    // Continuous requests alternate
    do_reset();
    fork
      begin burst(0, 32'h400, 1, 0, 0); burst(0, 32'h500, 1, 0, 0); end
      begin burst(1, 32'h600, 1, 0, 0); burst(1, 32'h700, 1, 0, 0); end
    join
    chk("t3_grants", enc(1'b0), 32'h0101);
    chk("t3_beats", enc(1'b1), 32'h2222);

    // W valid three cycles ahead of AW
    do_reset();
    fork
      burst(1, 32'h800, 2, 3, 0);
      repeat (3) begin
        @(negedge clk);
        chk("t4_early_swready", swready[1], 0);
        chk("t4_early_mwvalid", mwvalid, 0);
      end
    join
    chk("t4_grants", enc(1'b0), 32'h1);
    chk("t4_beats", enc(1'b1), 32'h3);

    // AW stall then toggling W ready
    do_reset();
    aw_stall = 5;
    w_toggle = 1'b1;
    fork
      burst(0, 32'hA00, 3, 0, 0);
      begin
        @(negedge clk);
        chk("t5_arb_mawvalid", mawvalid, 0);
        repeat (4) begin
          @(negedge clk);
          chk("t5_stall_mawvalid", mawvalid, 1);
          chk("t5_stall_mawaddr", mawaddr, 32'hA00);
          chk("t5_stall_sawready", sawready, 0);
        end
      end
    join
    w_toggle = 1'b0;
    chk("t5_grants", enc(1'b0), 32'h0);
    chk("t5_beats", enc(1'b1), 32'h4);

    // Reset after beat 2 of a len-7 burst; requester 0 must win afterwards
    do_reset();
    burst(0, 32'hB00, 0, 0, 0);
    chk("t6_pre_beats", enc(1'b1), 32'h1);
    base = dut_beats;
    fork
      burst(1, 32'hC00, 7, 0, 0);
      begin
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
          @(posedge clk);
          if (dut_beats >= base + 2) seen = 1'b1;
        end
        if (!seen) timeout("t6_two_beats");
        #1;
        rstnn = 1'b0;
        @(negedge clk);
        chk("t6_reset_outputs", {sawready, swready, mawvalid, mwvalid}, '0);
        repeat (2) @(posedge clk);
        #1;
        rstnn = 1'b1;
      end
    join
    chk("t6_beats_forwarded", dut_beats, base + 2);
    grant_log.delete();
    beats_log.delete();
    fork
      burst(0, 32'hD00, 1, 0, 0);
      burst(1, 32'hE00, 1, 0, 0);
    join
    chk("t6_grants_after_reset", enc(1'b0), 32'h01);
    chk("t6_beats_after_reset", enc(1'b1), 32'h22);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
